// File: rtl/pfgen_stride_if.sv
// pfgen_stride_if: prefetch-op fluid channel from the stride generator to the prefetch engine.
interface pfgen_stride_if #(
  parameter int AW = 50,
  parameter int SW = 12
);
  logic valid;
  logic retry;
  logic [AW-1:0] laddr;
  logic [SW-1:0] stride;
  logic [3:0] count;
  modport master (output valid, laddr, stride, count, input retry);
  modport slave (input valid, laddr, stride, count, output retry);
endinterface

// File: rtl/pfgen_stride.sv
// pfgen_stride: per-PC stride table that issues one prefetch op once a stride is confirmed.
module pfgen_stride #(
  parameter int ENTRIES = 16,
  parameter int PCW = 16,
  parameter int AW = 50,
  parameter int SW = 12,
  parameter int DEGREE = 4,
  parameter int THRESH = 2
) (
  input logic clk,
  input logic reset,
  input logic ldobs_valid,
  input logic [PCW-1:0] ldobs_pc,
  input logic [AW-1:0] ldobs_laddr,
  input logic flush,
  pfgen_stride_if.master pfgtopfe,
  output logic [15:0] drop_count
);
  localparam int IW = $clog2(ENTRIES);
  typedef struct packed {
    logic [AW-1:0] laddr;
    logic [SW-1:0] stride;
    logic [3:0] count;
  } op_t;
  logic [ENTRIES-1:0] v_q;
  logic [PCW-IW-1:0] tag_q [ENTRIES];
  logic [AW-1:0] last_q [ENTRIES];
  logic [SW-1:0] str_q [ENTRIES];
  logic [1:0] conf_q [ENTRIES];
  logic [IW-1:0] idx;
  logic [PCW-IW-1:0] tag;
  logic [AW-1:0] delta, str_x;
  logic [SW-1:0] str_d;
  logic [1:0] conf_d;
  logic obs, hit, same, fits, trig, load, op_valid;
  op_t op_q, op_d;
  always_comb begin
    idx = ldobs_pc[IW-1:0];
    tag = ldobs_pc[PCW-1:IW];
    obs = ldobs_valid && !flush;
    hit = v_q[idx] && tag_q[idx] == tag;
    delta = ldobs_laddr - last_q[idx];
    str_x = {{(AW-SW){str_q[idx][SW-1]}}, str_q[idx]};
    same = delta == str_x && |str_q[idx];
    fits = &delta[AW-1:SW-1] || ~|delta[AW-1:SW-1];
    conf_d = same ? (conf_q[idx] == 2'd3 ? 2'd3 : conf_q[idx] + 2'd1) : 2'd0;
    str_d = same ? str_q[idx] : fits ? delta[SW-1:0] : '0;
    trig = obs && hit && conf_d >= 2'(THRESH);
    load = trig && (!op_valid || !pfgtopfe.retry);
    op_d = '{laddr: ldobs_laddr + {{(AW-SW){str_d[SW-1]}}, str_d}, stride: str_d, count: 4'(DEGREE)};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < ENTRIES; i++) conf_q[i] <= '0;
    end else if (flush) begin
      v_q <= '0;
    end else if (ldobs_valid) begin
      v_q[idx] <= 1'b1;
      conf_q[idx] <= hit ? conf_d : 2'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (obs && !reset) begin
      tag_q[idx] <= tag;
      last_q[idx] <= ldobs_laddr;
      str_q[idx] <= hit ? str_d : '0;
    end
  end
  // A trigger that cannot load can only mean the held op is being retried.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_q <= '0;
      drop_count <= '0;
    end else begin
      if (load) begin
        op_valid <= 1'b1;
        op_q <= op_d;
      end else if (!pfgtopfe.retry) begin
        op_valid <= 1'b0;
      end
      if (trig && !load && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
  assign pfgtopfe.valid = op_valid;
  assign pfgtopfe.laddr = op_q.laddr;
  assign pfgtopfe.stride = op_q.stride;
  assign pfgtopfe.count = op_q.count;
endmodule

// File: tb/tb_pfgen_stride.sv
// tb_pfgen_stride: directed vector table plus randomized run against a behavioural stride-table model.
module tb_pfgen_stride;
  localparam longint MASK = (longint'(1) << 50) - 1;
  localparam longint HALF = longint'(1) << 49;
  logic clk = 1'b0;
  logic reset, ldobs_valid, flush;
  logic [15:0] ldobs_pc;
  logic [49:0] ldobs_laddr;
  logic [15:0] drop_count;
  pfgen_stride_if #(.AW(50), .SW(12)) pf ();
  pfgen_stride dut (
    .clk(clk),
    .reset(reset),
    .ldobs_valid(ldobs_valid),
    .ldobs_pc(ldobs_pc),
    .ldobs_laddr(ldobs_laddr),
    .flush(flush),
    .pfgtopfe(pf.master),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  typedef struct {
    logic o;
    logic [15:0] pc;
    logic [49:0] a;
    logic r, f, rs;
    logic ev;
    logic [49:0] el;
    int es;
    int ed;
  } vec_t;
  vec_t vt[$];
  bit mv[16];
  int mtag[16], mconf[16];
  longint mlast[16], mstr[16];
  bit ov;
  longint ol, os;
  int mdrop;
  function automatic void add(logic o, logic [15:0] p, logic [49:0] a, logic r, logic f, logic rs,
                              logic ev, logic [49:0] el, int es, int ed);
    vt.push_back('{o, p, a, r, f, rs, ev, el, es, ed});
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask
  task automatic model(input logic o, input logic [15:0] p, input logic [49:0] a, input logic r,
                       input logic f, input logic rs);
    int i, t;
    bit trig;
    longint d;
    trig = 0;
    i = int'(p) % 16;
    t = int'(p) / 16;
    if (rs) begin
      for (int k = 0; k < 16; k++) begin
        mv[k] = 0;
        mconf[k] = 0;
      end
      ov = 0; ol = 0; os = 0; mdrop = 0;
      return;
    end
    if (f) begin
      for (int k = 0; k < 16; k++) mv[k] = 0;
    end else if (o) begin
      if (!mv[i] || mtag[i] != t) begin
        mv[i] = 1; mtag[i] = t; mlast[i] = longint'(a); mstr[i] = 0; mconf[i] = 0;
      end else begin
        d = (longint'(a) - mlast[i]) & MASK;
        if (d >= HALF) d = d - 2 * HALF;
        if (d == mstr[i] && mstr[i] != 0) mconf[i] = mconf[i] == 3 ? 3 : mconf[i] + 1;
        else begin
          mconf[i] = 0;
          mstr[i] = (d >= -2048 && d <= 2047) ? d : 0;
        end
        mlast[i] = longint'(a);
        trig = mconf[i] >= 2;
      end
    end
    if (trig) begin
      if (!ov || !r) begin
        ov = 1;
        ol = (longint'(a) + mstr[i]) & MASK;
        os = mstr[i];
      end else if (mdrop < 65535) mdrop++;
    end else if (ov && !r) ov = 0;
  endtask
  task automatic step(input logic o, input logic [15:0] p, input logic [49:0] a, input logic r,
                      input logic f, input logic rs);
    ldobs_valid = o; ldobs_pc = p; ldobs_laddr = a; pf.retry = r; flush = f; reset = rs;
    @(posedge clk);
    model(o, p, a, r, f, rs);
    #1;
  endtask
  task automatic check_model(input string n);
    logic [11:0] s12;
    s12 = os[11:0];
    chk({n, " valid"}, 64'(pf.valid), 64'(ov));
    chk({n, " drop"}, 64'(drop_count), 64'(mdrop));
    if (ov) begin
      chk({n, " laddr"}, 64'(pf.laddr), 64'(ol));
      chk({n, " stride"}, 64'(pf.stride), 64'(s12));
      chk({n, " count"}, 64'(pf.count), 64'd4);
    end
  endtask
  logic [15:0] pcs[4] = '{16'h0010, 16'h1010, 16'h0022, 16'h0035};
  longint strs[5] = '{64, -128, 8, 65536, -3};
  longint base[4], sstr[4];
  initial begin
    logic [11:0] e12;
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 'h10, 'h1000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h10, 'h1040, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h10, 'h1080, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h10, 'h10C0, 0, 0, 0, 1, 'h1100, 64, 0);
    add(1, 'h10, 'h1100, 0, 0, 0, 1, 'h1140, 64, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h22, 'h8000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h22, 'h7F80, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h22, 'h7F00, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h22, 'h7E80, 0, 0, 0, 1, 'h7E00, -128, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h15, 'h2000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h15, 'h2040, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h15, 'h2080, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h15, 'h20C0, 1, 0, 0, 1, 'h2100, 64, 0);
    add(1, 'h15, 'h2100, 1, 0, 0, 1, 'h2100, 64, 1);
    add(0, 0, 0, 1, 0, 0, 1, 'h2100, 64, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h1010, 'h1140, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h10, 'h1140, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h10, 'h1180, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h10, 'h11C0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h10, 'h1200, 0, 0, 0, 1, 'h1240, 64, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h30, 'h0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h30, 'h10000, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h30, 'h20000, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h30, 'h30000, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h30, 'h40000, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3000, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3010, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3020, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3030, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3040, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3050, 0, 1, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3060, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3070, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3080, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h47, 'h3090, 1, 0, 0, 1, 'h30A0, 16, 1);
    add(1, 'h47, 'h30A0, 1, 0, 0, 1, 'h30A0, 16, 2);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    ldobs_valid = 0; ldobs_pc = 0; ldobs_laddr = 0; pf.retry = 0; flush = 0; reset = 1;
    repeat (2) @(negedge clk);
    foreach (vt[i]) begin
      step(vt[i].o, vt[i].pc, vt[i].a, vt[i].r, vt[i].f, vt[i].rs);
      e12 = vt[i].es[11:0];
      chk($sformatf("vec%0d valid", i), 64'(pf.valid), 64'(vt[i].ev));
      chk($sformatf("vec%0d drop", i), 64'(drop_count), 64'(vt[i].ed));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d laddr", i), 64'(pf.laddr), 64'(vt[i].el));
        chk($sformatf("vec%0d stride", i), 64'(pf.stride), 64'(e12));
        chk($sformatf("vec%0d count", i), 64'(pf.count), 64'd4);
      end
    end
    step(0, 0, 0, 0, 0, 1);
    check_model("rnd_reset");
    for (int k = 0; k < 4; k++) begin
      base[k] = longint'(k + 1) * 'h100000;
      sstr[k] = strs[$urandom_range(0, 4)];
    end
    for (int i = 0; i < 800; i++) begin
      int k;
      logic o, r, f, rs;
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) sstr[k] = strs[$urandom_range(0, 4)];
      o = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) == 0;
      f = $urandom_range(0, 49) == 0;
      rs = $urandom_range(0, 99) == 0;
      if (o) base[k] = (base[k] + sstr[k]) & MASK;
      step(o, pcs[k], base[k][49:0], r, f, rs);
      check_model($sformatf("rnd%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
